nivel_control: RTL

NIVEL_CONTROL -- requirements
Module: nivel_control

---
 rtl/nivel_control.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nivel_control.sv
// nivel_control: game-progress controller for the frog game.
// Tracks level, lives and goal crossings, and emits a one-cycle load pulse
// (NCT_CN_OUT) whenever the vehicle-level stage must reload its patterns.
// Optional feature: define NIVEL_CONTROL_BONUS_LIFE_EN to grant one extra
// life (saturating) on every level advance.
module nivel_control #(
    parameter int DATAWIDTH_NVL   = 2,
    parameter int DATAWIDTH_LIVES = 2,
    parameter int LIVES_INIT      = 3,
    parameter int CROSS_PER_LEVEL = 4
) (
    input  logic                       NCT_CLOCK,
    input  logic                       NCT_RESET,
    input  logic                       NCT_START_IN,
    input  logic                       NCT_WIN_IN,
    input  logic                       NCT_CRASH_IN,
    output logic [DATAWIDTH_NVL-1:0]   NCT_NV_OUT,
    output logic                       NCT_CN_OUT,
    output logic [DATAWIDTH_LIVES-1:0] NCT_LIVES_OUT,
    output logic [3:0]                 NCT_CROSS_OUT,
    output logic                       NCT_OVER_OUT,
    output logic                       NCT_DONE_OUT
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        OVER,
        DONE
    } state_t;

    localparam logic [DATAWIDTH_NVL-1:0]   LEVEL_MAX  = DATAWIDTH_NVL'(3);
    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_ONE  = DATAWIDTH_LIVES'(1);
    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_LOAD = DATAWIDTH_LIVES'(LIVES_INIT);
    localparam logic [3:0]                 CROSS_LAST = 4'(CROSS_PER_LEVEL - 1);
`ifdef NIVEL_CONTROL_BONUS_LIFE_EN
    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_MAX  = {DATAWIDTH_LIVES{1'b1}};
`endif

    state_t                     state_q, state_d;
    logic [DATAWIDTH_NVL-1:0]   level_q, level_d;
    logic [DATAWIDTH_LIVES-1:0] lives_q, lives_d;
    logic [3:0]                 cross_q, cross_d;
    logic                       cn_q, over_q, done_q;
    logic                       start_prev_q;
    logic                       start_edge;

    // A press counts only on a 0->1 transition of the button level.
    assign start_edge = NCT_START_IN & ~start_prev_q;

    // Next-state and next-datapath decisions for the game FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        cross_d = cross_q;

        unique case (state_q)
            IDLE, OVER, DONE: begin
                if (start_edge) begin
                    state_d = LOAD;
                    level_d = '0;
                    lives_d = LIVES_LOAD;
                    cross_d = '0;
                end
            end

            // Reload lasts a single cycle; inputs are ignored here.
            LOAD: state_d = PLAY;

            PLAY: begin
                // Crash wins over a coincident goal pulse.
                if (NCT_CRASH_IN) begin
                    if (lives_q > LIVES_ONE) begin
                        lives_d = lives_q - LIVES_ONE;
                        state_d = LOAD;
                    end else begin
                        lives_d = '0;
                        state_d = OVER;
                    end
                end else if (NCT_WIN_IN) begin
                    if (cross_q < CROSS_LAST) begin
                        cross_d = cross_q + 4'd1;
                    end else if (level_q < LEVEL_MAX) begin
                        level_d = level_q + DATAWIDTH_NVL'(1);
                        cross_d = '0;
                        state_d = LOAD;
`ifdef NIVEL_CONTROL_BONUS_LIFE_EN
                        if (lives_q != LIVES_MAX) begin
                            lives_d = lives_q + LIVES_ONE;
                        end
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and registered-output update; synchronous active-low reset.
    always_ff @(posedge NCT_CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!NCT_RESET) begin
            state_q      <= IDLE;
            level_q      <= '0;
            lives_q      <= LIVES_LOAD;
            cross_q      <= '0;
            cn_q         <= 1'b0;
            over_q       <= 1'b0;
            done_q       <= 1'b0;
            // A button held through reset must be released before it counts.
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            cross_q      <= cross_d;
            cn_q         <= (state_d == LOAD);
            over_q       <= (state_d == OVER);
            done_q       <= (state_d == DONE);
            start_prev_q <= NCT_START_IN;
        end
    end

    assign NCT_NV_OUT    = level_q;
    assign NCT_CN_OUT    = cn_q;
    assign NCT_LIVES_OUT = lives_q;
    assign NCT_CROSS_OUT = cross_q;
    assign NCT_OVER_OUT  = over_q;
    assign NCT_DONE_OUT  = done_q;

endmodule
